spi_master_arb: RTL and testbench

Two-requester SPI master that shares one SPI bus (sclk, mosi, cs, miso) between two on-chip clients.
- Arbitrates round-robin between the two requesters.
- Serialises one 8-bit frame per grant, MSB first, and captures 8 bits of miso.
- Generates sclk and cs so that a negedge-sampling, cs-active-low SPI receiver captures each byte cleanly.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_tick.sv | 25 ++
 rtl/spi_master_arb.sv | 159 +++++++++++++++
 tb/tb_spi_master_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the two-requester SPI master.
package spi_pkg;

    localparam int BITS = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/spi_clk_tick.sv
// sclk half-period divider: pulses tick every CLK_DIV enabled cycles, held at zero while disabled.
module spi_clk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    logic [7:0] div;

    assign tick = en && (div == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (!en || tick) begin
            div <= '0;
        end else begin
            div <= div + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_arb.sv
// Round-robin arbiter in front of a single SPI master; one 8-bit frame per grant, MSB first.
module spi_master_arb
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic [BITS-1:0] tx0,
    output logic            gnt0,
    input  logic            req1,
    input  logic [BITS-1:0] tx1,
    output logic            gnt1,
    output logic            done,
    output logic            done_id,
    output logic [BITS-1:0] rx_dat,
    output logic            busy,
    output logic            sclk,
    output logic            mosi,
    output logic            cs,
    input  logic            miso
);

    localparam logic [3:0] LAST_BIT = 4'(BITS);

    state_t          state, state_nx;
    logic            tick;
    logic            pick;
    logic            last_grant, last_grant_nx;
    logic            gid, gid_nx;
    logic [BITS-1:0] tx_sr, tx_sr_nx;
    logic [BITS-1:0] rx_shift, rx_shift_nx;
    logic [BITS-1:0] rx_dat_nx;
    logic [3:0]      bit_cnt, bit_cnt_nx;
    logic            sclk_nx, mosi_nx, cs_nx, busy_nx;
    logic            gnt0_nx, gnt1_nx, done_nx, done_id_nx;

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != IDLE),
        .tick  (tick)
    );

    // On contention the requester that was not served last wins.
    assign pick = (req0 && req1) ? ~last_grant : req1;

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        gid_nx        = gid;
        tx_sr_nx      = tx_sr;
        rx_shift_nx   = rx_shift;
        rx_dat_nx     = rx_dat;
        bit_cnt_nx    = bit_cnt;
        sclk_nx       = sclk;
        mosi_nx       = mosi;
        cs_nx         = cs;
        busy_nx       = busy;
        done_id_nx    = done_id;
        gnt0_nx       = 1'b0;
        gnt1_nx       = 1'b0;
        done_nx       = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt0_nx       = (pick == REQ0);
                    gnt1_nx       = (pick == REQ1);
                    gid_nx        = pick;
                    last_grant_nx = pick;
                    tx_sr_nx      = (pick == REQ1) ? tx1 : tx0;
                    mosi_nx       = tx_sr_nx[BITS-1];
                    busy_nx       = 1'b1;
                    cs_nx         = 1'b0;
                    bit_cnt_nx    = '0;
                    state_nx      = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_nx  = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk) begin
                        sclk_nx     = 1'b0;
                        rx_shift_nx = {rx_shift[BITS-2:0], miso};
                        if (bit_cnt < LAST_BIT) bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (bit_cnt == LAST_BIT) begin
                        // The would-be rising edge after the last bit is spent low.
                        state_nx = HOLD;
                    end else begin
                        sclk_nx  = 1'b1;
                        tx_sr_nx = {tx_sr[BITS-2:0], 1'b0};
                        mosi_nx  = tx_sr[BITS-2];
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_nx      = 1'b1;
                    mosi_nx    = 1'b0;
                    rx_dat_nx  = rx_shift;
                    done_nx    = 1'b1;
                    done_id_nx = gid;
                    state_nx   = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= REQ1;
            gid        <= REQ0;
            tx_sr      <= '0;
            rx_shift   <= '0;
            rx_dat     <= '0;
            bit_cnt    <= '0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs         <= 1'b1;
            busy       <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            gid        <= gid_nx;
            tx_sr      <= tx_sr_nx;
            rx_shift   <= rx_shift_nx;
            rx_dat     <= rx_dat_nx;
            bit_cnt    <= bit_cnt_nx;
            sclk       <= sclk_nx;
            mosi       <= mosi_nx;
            cs         <= cs_nx;
            busy       <= busy_nx;
            gnt0       <= gnt0_nx;
            gnt1       <= gnt1_nx;
            done       <= done_nx;
            done_id    <= done_id_nx;
        end
    end

endmodule

// File: tb/tb_spi_master_arb.sv
// Bench for spi_master_arb: timeline model of the frame checked every cycle plus directed scenarios.
`timescale 1ns/1ps
module tb_spi_master_arb;

    localparam int D = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
    logic       inv = 1'b0;
    logic       gnt0, gnt1, done, done_id, busy, sclk, mosi, cs, miso;
    logic [7:0] rx_dat;

    logic       b_req0 = 1'b0;
    logic [7:0] b_tx0 = 8'h00;
    logic       b_gnt0, b_gnt1, b_done, b_done_id, b_busy, b_sclk, b_mosi, b_cs;
    logic [7:0] b_rx_dat;

    assign miso = mosi ^ inv;

    spi_master_arb #(.CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .tx0(tx0), .gnt0(gnt0),
        .req1(req1), .tx1(tx1), .gnt1(gnt1),
        .done(done), .done_id(done_id), .rx_dat(rx_dat), .busy(busy),
        .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso)
    );

    spi_master_arb #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .tx0(b_tx0), .gnt0(b_gnt0),
        .req1(1'b0), .tx1(8'h00), .gnt1(b_gnt1),
        .done(b_done), .done_id(b_done_id), .rx_dat(b_rx_dat), .busy(b_busy),
        .sclk(b_sclk), .mosi(b_mosi), .cs(b_cs), .miso(b_mosi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        chk(name, {24'b0, act}, {24'b0, exp});
    endtask

    // Model: a frame is a fixed timeline of 18 half-periods after the grant, then a one half-period gap.
    int         m_k = -1;
    logic       m_last = 1'b1, m_id = 1'b0, m_inv = 1'b0, m_did = 1'b0;
    logic [7:0] m_tx = 8'h00, m_rx = 8'h00;

    always @(negedge clk) begin
        int   h, idx;
        logic e_cs, e_sclk, e_mosi;
        if (!rst_n) begin
            m_k = -1; m_last = 1'b1; m_did = 1'b0; m_rx = 8'h00;
            chk1("rst_cs", cs, 1'b1);
            chk1("rst_sclk", sclk, 1'b0);
            chk1("rst_mosi", mosi, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_gnt", gnt0 | gnt1, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk1("rst_done_id", done_id, 1'b0);
            chk8("rst_rx_dat", rx_dat, 8'h00);
        end else begin
            if (m_k < 0) begin
                e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
            end else begin
                h   = m_k / D;
                idx = (h == 0) ? 0 : (h - 1) / 2;
                if (idx > 7) idx = 7;
                e_cs   = (m_k < 18 * D) ? 1'b0 : 1'b1;
                e_sclk = (h % 2 == 1) && (h < 16);
                e_mosi = (m_k < 18 * D) ? m_tx[7 - idx] : 1'b0;
                if (m_k == 18 * D) begin
                    m_did = m_id;
                    m_rx  = m_tx ^ {8{m_inv}};
                end
            end
            chk1("cs", cs, e_cs);
            chk1("sclk", sclk, e_sclk);
            chk1("mosi", mosi, e_mosi);
            chk1("busy", busy, m_k >= 0);
            chk1("gnt0", gnt0, (m_k == 0) && !m_id);
            chk1("gnt1", gnt1, (m_k == 0) && m_id);
            chk1("done", done, m_k == 18 * D);
            chk1("done_id", done_id, m_did);
            chk8("rx_dat", rx_dat, m_rx);
            if (m_k < 0) begin
                if (req0 || req1) begin
                    m_id   = (req0 && req1) ? !m_last : req1;
                    m_last = m_id;
                    m_tx   = m_id ? tx1 : tx0;
                    m_inv  = inv;
                    m_k    = 0;
                end
            end else begin
                m_k++;
                if (m_k == 19 * D) m_k = -1;
            end
        end
    end

    logic       sel = 1'b0;
    logic       x_cs, x_sclk, x_mosi, x_gnt0, x_gnt1, x_done, x_done_id;
    logic [7:0] x_rx;
    assign x_cs      = sel ? b_cs      : cs;
    assign x_sclk    = sel ? b_sclk    : sclk;
    assign x_mosi    = sel ? b_mosi    : mosi;
    assign x_gnt0    = sel ? b_gnt0    : gnt0;
    assign x_gnt1    = sel ? b_gnt1    : gnt1;
    assign x_done    = sel ? b_done    : done;
    assign x_done_id = sel ? b_done_id : done_id;
    assign x_rx      = sel ? b_rx_dat  : rx_dat;

    int         r_cs_low, r_falls, r_rises, r_sclk_hi, r_mosi_hi, r_pre_hi;
    logic [7:0] r_byte, r_rx;
    logic       r_did;

    // Observes one frame like a negedge-sampling SPI receiver; requester drops req on its grant.
    task automatic run_frame(input logic s);
        logic prev, got, seen_low;
        sel = s;
        r_cs_low = 0; r_falls = 0; r_rises = 0; r_sclk_hi = 0; r_mosi_hi = 0; r_pre_hi = 0;
        r_byte = 8'h00; r_rx = 8'h00; r_did = 1'b0;
        got = 1'b0; seen_low = 1'b0; prev = x_sclk;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (!x_cs) begin
                r_cs_low++; seen_low = 1'b1;
                if (x_mosi) r_mosi_hi++;
            end else if (!seen_low) begin
                r_pre_hi++;
            end
            if (x_sclk) r_sclk_hi++;
            if (prev && !x_sclk) begin r_falls++; r_byte = {r_byte[6:0], x_mosi}; end
            if (!prev && x_sclk) r_rises++;
            prev = x_sclk;
            if (x_gnt0) begin if (s) b_req0 = 1'b0; else req0 = 1'b0; end
            if (x_gnt1) req1 = 1'b0;
            if (x_done) begin got = 1'b1; r_did = x_done_id; r_rx = x_rx; end
        end
        chk1("frame_done_seen", got, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk1("reset_cs", cs, 1'b1);
        chk1("reset_sclk", sclk, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_cs_b", b_cs, 1'b1);

        // 1: single requester, inverted echo on miso
        @(posedge clk); #2;
        inv = 1'b1; tx0 = 8'hA5; req0 = 1'b1;
        run_frame(1'b0);
        chk8("t1_recv_byte", r_byte, 8'hA5);
        chk("t1_falls", r_falls, 8);
        chk("t1_cs_low", r_cs_low, 36);
        chk1("t1_done_id", r_did, 1'b0);
        chk8("t1_rx_dat", r_rx, 8'h5A);

        // 2: loopback on requester 1, rx_dat holds after done
        @(posedge clk); #2;
        inv = 1'b0; tx1 = 8'h3C; req1 = 1'b1;
        run_frame(1'b0);
        chk8("t2_rx_dat", r_rx, 8'h3C);
        chk1("t2_done_id", r_did, 1'b1);
        repeat (10) @(negedge clk);
        chk8("t2_rx_hold", rx_dat, 8'h3C);
        chk1("t2_id_hold", done_id, 1'b1);

        // 3: contention straight out of reset, then round-robin
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tx0 = 8'h11; tx1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
        run_frame(1'b0);
        chk1("t3_first_id", r_did, 1'b0);
        chk8("t3_first_rx", r_rx, 8'h11);
        run_frame(1'b0);
        chk1("t3_second_id", r_did, 1'b1);
        chk8("t3_second_rx", r_rx, 8'h22);
        chk1("t3_cs_gap", r_pre_hi >= D, 1'b1);
        @(posedge clk); #2;
        req0 = 1'b1; req1 = 1'b1;
        run_frame(1'b0);
        chk1("t3_rr_id", r_did, 1'b0);
        run_frame(1'b0);
        chk1("t3_drain_id", r_did, 1'b1);

        // 4: reset after the third falling sclk edge
        @(posedge clk); #2;
        tx0 = 8'hC3; req0 = 1'b1;
        begin
            int   f;
            logic p;
            f = 0; p = sclk;
            for (int c = 0; c < 200 && f < 3; c++) begin
                @(negedge clk);
                if (gnt0) req0 = 1'b0;
                if (p && !sclk) f++;
                p = sclk;
            end
            chk("t4_falls_before_reset", f, 3);
        end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk1("t4_cs_async", cs, 1'b1);
        chk1("t4_sclk_async", sclk, 1'b0);
        chk1("t4_mosi_async", mosi, 1'b0);
        chk1("t4_done_async", done, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tx0 = 8'hFF; req0 = 1'b1;
        run_frame(1'b0);
        chk8("t4_recv_byte", r_byte, 8'hFF);
        chk8("t4_rx_dat", r_rx, 8'hFF);
        chk("t4_cs_low", r_cs_low, 36);

        // 5: request pulsed during GAP and withdrawn before IDLE
        @(posedge clk); #2;
        tx0 = 8'h5A; req0 = 1'b1;
        run_frame(1'b0);
        @(posedge clk); #2 req0 = 1'b1;
        @(posedge clk); #2 req0 = 1'b0;
        begin
            int g;
            g = 0;
            repeat (60) begin
                @(negedge clk);
                if (gnt0 || gnt1 || !cs) g++;
            end
            chk("t5_no_grant", g, 0);
            chk1("t5_busy_low", busy, 1'b0);
        end

        // 6: CLK_DIV=1 instance
        @(posedge clk); #2;
        b_tx0 = 8'h80; b_req0 = 1'b1;
        run_frame(1'b1);
        chk("t6_cs_low", r_cs_low, 18);
        chk("t6_falls", r_falls, 8);
        chk("t6_rises", r_rises, 8);
        chk("t6_sclk_hi", r_sclk_hi, 8);
        chk("t6_mosi_hi", r_mosi_hi, 3);
        chk8("t6_recv_byte", r_byte, 8'h80);
        chk8("t6_rx_dat", r_rx, 8'h80);
        chk1("t6_done_id", r_did, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
